oled_cmd_responder: RTL
=======================

// Module: oled_cmd_responder
// PURPOSE
//  SPI-side responder for the PmodOLED command stream: the receiving end of the SSD1306 init/command link.
//  Deserializes CS/SCLK/SDO/DC, decodes 1/2/3-byte SSD1306 commands, mirrors display state in registers, and flags protocol/power errors.
//  Instanced in the system test harness and on-board loopback builds to check the OLED init controller and page writers.
// PARAMETERS
//  SYNC_STAGES  2   synchronizer depth for CS/SCLK/SDO/DC/RES/VDD/VBAT (>=2)
//  CNT_W        16  width of byte counters
// PORTS
//  CLK          in   1      system clock; must be >=4x SCLK frequency
//  RST          in   1      asynchronous, active-high reset
//  CS           in   1      SPI chip select, active low
//  SCLK         in   1      SPI clock, idles high; data sampled on SCLK rising edge
//  SDO          in   1      SPI data from controller, MSB first
//  DC           in   1      0=command byte, 1=data (GDDRAM) byte; sampled with bit 0
//  RES          in   1      display reset, active low
//  VDD          in   1      logic supply enable, active low (0=on)
//  VBAT         in   1      panel supply enable, active low (0=on)
//  BYTE_VLD     out  1      1-cycle pulse: byte received
//  BYTE_DATA    out  8      last received byte (held)
//  BYTE_DC      out  1      DC value of last byte
//  DISP_ON      out  1      1 after 0xAF, 0 after 0xAE
//  CHG_PUMP     out  1      1 when 0x8D arg bit2=1
//  CONTRAST     out  8      0x81 argument
//  PRECHARGE    out  8      0xD9 argument
//  COM_CFG      out  8      0xDA argument
//  SEG_REMAP    out  1      0xA0->0, 0xA1->1
//  COM_REV      out  1      0xC0->0, 0xC8->1
//  ENTIRE_ON    out  1      0xA5->1, 0xA4->0
//  CMD_CNT      out  CNT_W  command bytes received (wraps)
//  DATA_CNT     out  CNT_W  data bytes received (wraps)
//  ERR          out  4      sticky: [0] partial byte at CS rise, [1] byte while RES low,
//                           [2] byte while VDD off, [3] AF with CHG_PUMP=0 (or SEQ error)
// BEHAVIOUR
//  - RST: all outputs to SSD1306 defaults: DISP_ON=0, CHG_PUMP=0, CONTRAST=0x7F, PRECHARGE=0x22, COM_CFG=0x12,
//    SEG_REMAP=0, COM_REV=0, ENTIRE_ON=0, BYTE_DATA=0, BYTE_DC=0, BYTE_VLD=0, counters 0, ERR=0, FSM=IDLE.
//  - RES low (synchronized): same display-register defaults, FSM=IDLE, bit counter cleared; counters and ERR kept.
//  - Shift: on synchronized SCLK rise while CS low, shift SDO in; 8th bit -> BYTE_VLD pulse exactly 1 CLK later,
//    latency <= SYNC_STAGES+2 CLK from SCLK edge. CS high clears bit counter; if count was 1..7 set ERR[0].
//  - Bytes while RES low: ERR[1], not decoded, not counted. While VDD=1: ERR[2], still decoded/counted.
//  - DC=1 byte: DATA_CNT++, FSM unchanged (argument slots only accept DC=0).
//  - Decode FSM (command bytes only):
//    IDLE: 2-byte opcode {81,8D,D9,DA,20,A8,D3,D5,DB} -> ARG1 (opcode latched); 3-byte {21,22} -> ARG1;
//          single-byte opcodes update registers immediately; unknown opcodes counted, ignored.
//    ARG1: apply argument to latched opcode's register (unlisted ones discarded); 2-byte -> IDLE, 3-byte -> ARG2.
//    ARG2: discard byte -> IDLE.
//  - 0xAF with CHG_PUMP=0: DISP_ON still set, ERR[3] set.
//  - CMD_CNT/DATA_CNT wrap 2^CNT_W-1 -> 0. CS rise mid-argument does not reset FSM (matches SSD1306).
//  - Simultaneous RES assert and byte completion: RES wins, byte dropped.
// CONFIGURATION
//  SEQ_CHECK_EN defined: power-sequence tracker; ERR[3] additionally set if VBAT turns on before VDD on
//    plus one full RES low pulse, or on 0xAF while VBAT off.
//  SEQ_CHECK_EN undefined: tracker absent; ERR[3] only from 0xAF with CHG_PUMP=0.
// TESTING
//  1. Full init sequence AE,8D,14,D9,F1,81,0F,A1,C8,DA,20,AF with legal VDD/RES/VBAT -> DISP_ON=1, CHG_PUMP=1,
//     CONTRAST=0x0F, PRECHARGE=0xF1, COM_CFG=0x20, SEG_REMAP=1, COM_REV=1, CMD_CNT=12, ERR=0.
//  2. 5 bits then CS high, then full byte 0xA5 -> ERR[0]=1, ENTIRE_ON=1, CMD_CNT=1.
//  3. 0xAF without prior 8D,14 -> DISP_ON=1, ERR[3]=1.
//  4. 8D,14 then RES low 3 CLK mid-byte -> CHG_PUMP=0, partial byte discarded, FSM IDLE.
//  5. 0x21,0x00,0x7F then 0xA5 -> ENTIRE_ON=1 (args consumed, not decoded); 4 DC=1 bytes -> DATA_CNT=4.
//  6. SEQ_CHECK_EN: VBAT low before RES pulse -> ERR[3]=1; without macro -> ERR=0.

Source files
------------

// File: rtl/oled_cmd_responder.sv
// oled_cmd_responder: SPI-side receiver for the PmodOLED / SSD1306 command
// stream. Synchronizes the raw pins, deserializes bytes MSB first, decodes
// 1/2/3-byte SSD1306 commands into mirrored display registers and raises
// sticky protocol/power error flags.
//
// Optional feature: define SEQ_CHECK_EN to build the power-sequence tracker
// (VDD on, one full RES low pulse, then VBAT on; 0xAF needs VBAT on).
//
// Output handshake: BYTE_VLD is a single-cycle strobe with no ready/back-
// pressure; BYTE_DATA/BYTE_DC are valid in the strobe cycle and held until
// the next received byte.
module oled_cmd_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CS,
  input  logic             SCLK,
  input  logic             SDO,
  input  logic             DC,
  input  logic             RES,
  input  logic             VDD,
  input  logic             VBAT,
  output logic             BYTE_VLD,
  output logic [7:0]       BYTE_DATA,
  output logic             BYTE_DC,
  output logic             DISP_ON,
  output logic             CHG_PUMP,
  output logic [7:0]       CONTRAST,
  output logic [7:0]       PRECHARGE,
  output logic [7:0]       COM_CFG,
  output logic             SEG_REMAP,
  output logic             COM_REV,
  output logic             ENTIRE_ON,
  output logic [CNT_W-1:0] CMD_CNT,
  output logic [CNT_W-1:0] DATA_CNT,
  output logic [3:0]       ERR,
  output logic [1:0]       DBG_STATE
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARG1 = 2'd1,
    ST_ARG2 = 2'd2
  } state_t;

  // Synchronizer bit positions: {VBAT, VDD, RES, CS, SCLK, DC, SDO}.
  // Reset value matches idle pins: supplies off, RES/CS/SCLK high.
  localparam logic [6:0] SYNC_RST = 7'b111_1100;

  localparam logic [7:0] DEF_CONTRAST  = 8'h7F;
  localparam logic [7:0] DEF_PRECHARGE = 8'h22;
  localparam logic [7:0] DEF_COM_CFG   = 8'h12;

  // Opcodes that carry one argument byte.
  function automatic logic op_two(input logic [7:0] op);
    case (op)
      8'h81, 8'h8D, 8'hD9, 8'hDA, 8'h20,
      8'hA8, 8'hD3, 8'hD5, 8'hDB: op_two = 1'b1;
      default:                    op_two = 1'b0;
    endcase
  endfunction

  // Opcodes that carry two argument bytes.
  function automatic logic op_three(input logic [7:0] op);
    op_three = (op == 8'h21) || (op == 8'h22);
  endfunction

  logic [6:0]       raw;
  logic [6:0]       sync_q [SYNC_STAGES];
  logic [6:0]       sync_d [SYNC_STAGES];
  logic             vbat_s, vdd_s, res_s, cs_s, sclk_s, dc_s, sdo_s;
  logic             sclk_prev_q, sclk_prev_d;
  logic             res_prev_q, res_prev_d;
  logic             sclk_rise, res_fall, byte_done;
  logic [6:0]       shift_q, shift_d;
  logic [7:0]       new_byte;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  state_t           state_q, state_d;
  logic [7:0]       opcode_q, opcode_d;
  logic             byte_vld_q, byte_vld_d;
  logic [7:0]       byte_data_q, byte_data_d;
  logic             byte_dc_q, byte_dc_d;
  logic             disp_on_q, disp_on_d;
  logic             chg_pump_q, chg_pump_d;
  logic [7:0]       contrast_q, contrast_d;
  logic [7:0]       precharge_q, precharge_d;
  logic [7:0]       com_cfg_q, com_cfg_d;
  logic             seg_remap_q, seg_remap_d;
  logic             com_rev_q, com_rev_d;
  logic             entire_on_q, entire_on_d;
  logic [CNT_W-1:0] cmd_cnt_q, cmd_cnt_d;
  logic [CNT_W-1:0] data_cnt_q, data_cnt_d;
  logic [3:0]       err_q, err_d;

`ifdef SEQ_CHECK_EN
  typedef enum logic [1:0] {
    SQ_WAIT_VDD    = 2'd0,
    SQ_WAIT_RES_LO = 2'd1,
    SQ_WAIT_RES_HI = 2'd2,
    SQ_OK          = 2'd3
  } seq_t;
  seq_t seq_q, seq_d;
`else
  logic unused_vbat;
  assign unused_vbat = vbat_s;
`endif

  assign raw      = {VBAT, VDD, RES, CS, SCLK, DC, SDO};
  assign {vbat_s, vdd_s, res_s, cs_s, sclk_s, dc_s, sdo_s} = sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign res_fall  = ~res_s & res_prev_q;
  assign new_byte  = {shift_q, sdo_s};

  // Next value of the synchronizer chain and edge-detect history.
  always_comb begin
    sync_d[0] = raw;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    sclk_prev_d = sclk_s;
    res_prev_d  = res_s;
  end

  // Deserializer, command decoder, register mirror and error flags.
  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    state_d     = state_q;
    opcode_d    = opcode_q;
    byte_vld_d  = 1'b0;
    byte_data_d = byte_data_q;
    byte_dc_d   = byte_dc_q;
    disp_on_d   = disp_on_q;
    chg_pump_d  = chg_pump_q;
    contrast_d  = contrast_q;
    precharge_d = precharge_q;
    com_cfg_d   = com_cfg_q;
    seg_remap_d = seg_remap_q;
    com_rev_d   = com_rev_q;
    entire_on_d = entire_on_q;
    cmd_cnt_d   = cmd_cnt_q;
    data_cnt_d  = data_cnt_q;
    err_d       = err_q;
    byte_done   = 1'b0;
`ifdef SEQ_CHECK_EN
    seq_d       = seq_q;
`endif

    // Bit framing: CS high aborts a byte; a non-zero count there is a
    // truncated transfer.
    if (cs_s) begin
      bit_cnt_d = 3'd0;
      if (bit_cnt_q != 3'd0) err_d[0] = 1'b1;
    end else if (sclk_rise) begin
      shift_d   = new_byte[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      byte_done = (bit_cnt_q == 3'd7);
    end

    // RES assertion re-frames the link and wins over a completing byte.
    if (res_fall) begin
      bit_cnt_d = 3'd0;
      byte_done = 1'b0;
    end

    if (byte_done) begin
      byte_vld_d  = 1'b1;
      byte_data_d = new_byte;
      byte_dc_d   = dc_s;
      if (!res_s) begin
        err_d[1] = 1'b1;
      end else begin
        if (vdd_s) err_d[2] = 1'b1;
        if (dc_s) begin
          data_cnt_d = data_cnt_q + CNT_W'(1);
        end else begin
          cmd_cnt_d = cmd_cnt_q + CNT_W'(1);
          case (state_q)
            ST_IDLE: begin
              if (op_two(new_byte) || op_three(new_byte)) begin
                opcode_d = new_byte;
                state_d  = ST_ARG1;
              end else begin
                case (new_byte)
                  8'hAE: disp_on_d = 1'b0;
                  8'hAF: begin
                    disp_on_d = 1'b1;
                    if (!chg_pump_q) err_d[3] = 1'b1;
`ifdef SEQ_CHECK_EN
                    if (vbat_s) err_d[3] = 1'b1;
`endif
                  end
                  8'hA0: seg_remap_d = 1'b0;
                  8'hA1: seg_remap_d = 1'b1;
                  8'hC0: com_rev_d   = 1'b0;
                  8'hC8: com_rev_d   = 1'b1;
                  8'hA4: entire_on_d = 1'b0;
                  8'hA5: entire_on_d = 1'b1;
                  default: ;
                endcase
              end
            end
            ST_ARG1: begin
              case (opcode_q)
                8'h81:   contrast_d  = new_byte;
                8'h8D:   chg_pump_d  = new_byte[2];
                8'hD9:   precharge_d = new_byte;
                8'hDA:   com_cfg_d   = new_byte;
                default: ;
              endcase
              state_d = op_three(opcode_q) ? ST_ARG2 : ST_IDLE;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
    end

    // Display held in reset: registers forced to power-on values.
    if (!res_s) begin
      state_d     = ST_IDLE;
      disp_on_d   = 1'b0;
      chg_pump_d  = 1'b0;
      contrast_d  = DEF_CONTRAST;
      precharge_d = DEF_PRECHARGE;
      com_cfg_d   = DEF_COM_CFG;
      seg_remap_d = 1'b0;
      com_rev_d   = 1'b0;
      entire_on_d = 1'b0;
    end

`ifdef SEQ_CHECK_EN
    // Power-sequence tracker: VBAT may only be on once VDD is on and a
    // complete RES low pulse has been seen.
    case (seq_q)
      SQ_WAIT_VDD:    if (!vdd_s) seq_d = SQ_WAIT_RES_LO;
      SQ_WAIT_RES_LO: if (!res_s) seq_d = SQ_WAIT_RES_HI;
      SQ_WAIT_RES_HI: if (res_s)  seq_d = SQ_OK;
      default:        seq_d = SQ_OK;
    endcase
    if (vdd_s) seq_d = SQ_WAIT_VDD;
    if (!vbat_s && (seq_q != SQ_OK)) err_d[3] = 1'b1;
`endif
  end

  // Synchronizer chain and edge history.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
      sclk_prev_q <= 1'b1;
      res_prev_q  <= 1'b1;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      sclk_prev_q <= sclk_prev_d;
      res_prev_q  <= res_prev_d;
    end
  end

  // Decoder FSM and all registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      state_q     <= ST_IDLE;
      opcode_q    <= '0;
      byte_vld_q  <= 1'b0;
      byte_data_q <= '0;
      byte_dc_q   <= 1'b0;
      disp_on_q   <= 1'b0;
      chg_pump_q  <= 1'b0;
      contrast_q  <= DEF_CONTRAST;
      precharge_q <= DEF_PRECHARGE;
      com_cfg_q   <= DEF_COM_CFG;
      seg_remap_q <= 1'b0;
      com_rev_q   <= 1'b0;
      entire_on_q <= 1'b0;
      cmd_cnt_q   <= '0;
      data_cnt_q  <= '0;
      err_q       <= '0;
`ifdef SEQ_CHECK_EN
      seq_q       <= SQ_WAIT_VDD;
`endif
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      byte_vld_q  <= byte_vld_d;
      byte_data_q <= byte_data_d;
      byte_dc_q   <= byte_dc_d;
      disp_on_q   <= disp_on_d;
      chg_pump_q  <= chg_pump_d;
      contrast_q  <= contrast_d;
      precharge_q <= precharge_d;
      com_cfg_q   <= com_cfg_d;
      seg_remap_q <= seg_remap_d;
      com_rev_q   <= com_rev_d;
      entire_on_q <= entire_on_d;
      cmd_cnt_q   <= cmd_cnt_d;
      data_cnt_q  <= data_cnt_d;
      err_q       <= err_d;
`ifdef SEQ_CHECK_EN
      seq_q       <= seq_d;
`endif
    end
  end

  assign BYTE_VLD  = byte_vld_q;
  assign BYTE_DATA = byte_data_q;
  assign BYTE_DC   = byte_dc_q;
  assign DISP_ON   = disp_on_q;
  assign CHG_PUMP  = chg_pump_q;
  assign CONTRAST  = contrast_q;
  assign PRECHARGE = precharge_q;
  assign COM_CFG   = com_cfg_q;
  assign SEG_REMAP = seg_remap_q;
  assign COM_REV   = com_rev_q;
  assign ENTIRE_ON = entire_on_q;
  assign CMD_CNT   = cmd_cnt_q;
  assign DATA_CNT  = data_cnt_q;
  assign ERR       = err_q;
  assign DBG_STATE = state_q;

endmodule
